// File: rtl/latch_bank_sequencer.sv
// Round-robin sequencer that shares one level-sensitive latch bank among NREQ requesters.
// Each write runs data setup -> gate pulse -> hold -> ack, so latch data never moves while the gate is open.
module latch_bank_sequencer #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int GATE_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic                    clr_req,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    latch_g,
    output logic                    latch_rst,
    output logic [WIDTH-1:0]        latch_d
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(GATE_CYCLES + HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETUP,
        S_GATE,
        S_HOLD,
        S_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0] latch_d_q, latch_d_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             latch_g_q, latch_g_d;
    logic             latch_rst_q, latch_rst_d;

    logic [WIDTH-1:0] data_arr [NREQ];
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   pick;
    logic             found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First asserted request at or above the round-robin pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        latch_d_d = latch_d_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                end else if (found) begin
                    grant_d   = pick;
                    latch_d_d = data_arr[pick];
                    state_d   = S_SETUP;
                end
            end
            S_CLEAR: state_d = S_IDLE;
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_GATE;
            end
            S_GATE: begin
                if (cnt_q == CW'(GATE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        latch_g_d   = (state_d == S_GATE);
        latch_rst_d = (state_d == S_CLEAR);
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
            assign ack_d[gi] = (state_d == S_ACK) && (grant_d == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            latch_d_q   <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            latch_g_q   <= 1'b0;
            latch_rst_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            latch_d_q   <= latch_d_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            latch_g_q   <= latch_g_d;
            latch_rst_q <= latch_rst_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign latch_g   = latch_g_q;
    assign latch_rst = latch_rst_q;
    assign latch_d   = latch_d_q;

endmodule
